// File: rtl/vc_domain_arb_mux_pkg.sv
// Shared definitions for the domain-tagged arbitrating mux: domain encodings and clog2 helper.
package vc_domain_arb_mux_pkg;

  localparam int VC_DOMAIN_L = 0;
  localparam int VC_DOMAIN_H = 1;

  function automatic int vc_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/vc_domain_arb_mux_if.sv
// Request/response bundle of the domain mux; out_clear only exists with DOMAIN_FILTER_EN.
interface vc_domain_arb_mux_if
  import vc_domain_arb_mux_pkg::*;
#(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4,
  parameter int p_dbits   = 1
);
  localparam int p_sbits = vc_clog2(p_ninputs);

  logic [p_ninputs-1:0]         in_val;
  logic [p_ninputs-1:0]         in_rdy;
  logic [p_ninputs*p_nbits-1:0] in_msg;
  logic [p_ninputs*p_dbits-1:0] in_domain;
  logic                         out_val;
  logic                         out_rdy;
  logic [p_nbits-1:0]           out_msg;
  logic [p_dbits-1:0]           out_domain;
  logic [p_sbits-1:0]           out_sel;
`ifdef DOMAIN_FILTER_EN
  logic [p_dbits-1:0]           out_clear;

  modport slave (
    input  in_val, in_msg, in_domain, out_rdy, out_clear,
    output in_rdy, out_val, out_msg, out_domain, out_sel
  );
  modport master (
    output in_val, in_msg, in_domain, out_rdy, out_clear,
    input  in_rdy, out_val, out_msg, out_domain, out_sel
  );
`else
  modport slave (
    input  in_val, in_msg, in_domain, out_rdy,
    output in_rdy, out_val, out_msg, out_domain, out_sel
  );
  modport master (
    output in_val, in_msg, in_domain, out_rdy,
    input  in_rdy, out_val, out_msg, out_domain, out_sel
  );
`endif

endinterface

// File: rtl/vc_domain_arb_mux_arb.sv
// Round-robin / fixed-priority arbiter; the rotation pointer lives here and advances only on a taken grant.
module vc_rr_arb
  import vc_domain_arb_mux_pkg::*;
#(
  parameter int p_ninputs = 4,
  parameter int p_rr      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [p_ninputs-1:0] req,
  input  logic                 en,
  output logic [p_ninputs-1:0] grant
);
  localparam int p_sbits = vc_clog2(p_ninputs);

  logic [p_sbits-1:0]     ptr;
  logic [p_sbits-1:0]     base;
  logic [p_sbits-1:0]     gnt_idx;
  logic [p_ninputs-1:0]   req_rot;
  logic [p_ninputs-1:0]   first_rot;
  logic [2*p_ninputs-1:0] grant_dbl;
  logic                   found;

  assign base = (p_rr != 0) ? ptr : '0;

  // Rotate requests so the search always starts at bit 0, then rotate the winner back.
  assign req_rot = p_ninputs'({req, req} >> base);

  always_comb begin
    int sum;
    first_rot = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    sum       = 0;
    for (int k = 0; k < p_ninputs; k++) begin
      if (!found && req_rot[k]) begin
        found        = 1'b1;
        first_rot[k] = 1'b1;
        sum          = int'(base) + k;
        if (sum >= p_ninputs) sum = sum - p_ninputs;
        gnt_idx      = p_sbits'(sum);
      end
    end
  end

  assign grant_dbl = {first_rot, first_rot} << base;
  assign grant     = grant_dbl[2*p_ninputs-1:p_ninputs];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if ((p_rr != 0) && en && found) begin
      ptr <= (gnt_idx == p_sbits'(p_ninputs - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vc_domain_arb_mux.sv
// N-input domain-tagged val/rdy mux with arbitration and one registered output slot.
// DOMAIN_FILTER_EN: gate eligibility on in_domain[i] <= out_clear.
module vc_domain_arb_mux
  import vc_domain_arb_mux_pkg::*;
#(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4,
  parameter int p_dbits   = 1,
  parameter int p_rr      = 1
) (
  input  logic                clk,
  input  logic                reset,
  vc_domain_arb_mux_if.slave  bus
);
  localparam int p_sbits = vc_clog2(p_ninputs);

  logic                 load;
  logic [p_ninputs-1:0] elig;
  logic [p_ninputs-1:0] grant;
  logic [p_ninputs-1:0] xfer;
  logic [p_nbits-1:0]   msg_d;
  logic [p_dbits-1:0]   dom_d;
  logic [p_sbits-1:0]   sel_d;

  assign load = !bus.out_val || bus.out_rdy;

`ifdef DOMAIN_FILTER_EN
  // Ineligible inputs stay pending; they are never dropped.
  for (genvar i = 0; i < p_ninputs; i++) begin : g_elig
    assign elig[i] = bus.in_val[i] &&
                     (bus.in_domain[i*p_dbits +: p_dbits] <= bus.out_clear);
  end
`else
  assign elig = bus.in_val;
`endif

  vc_rr_arb #(
    .p_ninputs (p_ninputs),
    .p_rr      (p_rr)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .en    (load),
    .grant (grant)
  );

  assign xfer       = grant & {p_ninputs{load && reset}};
  assign bus.in_rdy = xfer;

  always_comb begin
    msg_d = '0;
    dom_d = '0;
    sel_d = '0;
    for (int i = 0; i < p_ninputs; i++) begin
      if (grant[i]) begin
        msg_d = bus.in_msg[i*p_nbits +: p_nbits];
        dom_d = bus.in_domain[i*p_dbits +: p_dbits];
        sel_d = p_sbits'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_val    <= 1'b0;
      bus.out_msg    <= '0;
      bus.out_domain <= p_dbits'(VC_DOMAIN_L);
      bus.out_sel    <= '0;
    end else if (load) begin
      bus.out_val <= |xfer;
      if (|xfer) begin
        bus.out_msg    <= msg_d;
        bus.out_domain <= dom_d;
        bus.out_sel    <= sel_d;
      end
    end
  end

endmodule

// File: tb/tb_vc_domain_arb_mux.sv
// Bench for vc_domain_arb_mux: round-robin and fixed-priority instances driven in lockstep.
module tb_vc_domain_arb_mux;
  import vc_domain_arb_mux_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  tb_val;
  logic [31:0] tb_msg;
  logic [3:0]  tb_dom;
  logic        tb_ordy;
`ifdef DOMAIN_FILTER_EN
  logic        tb_clear;
`endif

  int n_assert;
  int n_fail;
  bit chk_en;

  vc_domain_arb_mux_if #(.p_nbits(8), .p_ninputs(4), .p_dbits(1)) bus0 ();
  vc_domain_arb_mux_if #(.p_nbits(8), .p_ninputs(4), .p_dbits(1)) bus1 ();

  vc_domain_arb_mux #(.p_nbits(8), .p_ninputs(4), .p_dbits(1), .p_rr(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  vc_domain_arb_mux #(.p_nbits(8), .p_ninputs(4), .p_dbits(1), .p_rr(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  assign bus0.in_val = tb_val;  assign bus1.in_val = tb_val;
  assign bus0.in_msg = tb_msg;  assign bus1.in_msg = tb_msg;
  assign bus0.in_domain = tb_dom; assign bus1.in_domain = tb_dom;
  assign bus0.out_rdy = tb_ordy; assign bus1.out_rdy = tb_ordy;
`ifdef DOMAIN_FILTER_EN
  assign bus0.out_clear = tb_clear; assign bus1.out_clear = tb_clear;
`endif

  logic       o_val [2];
  logic [7:0] o_msg [2];
  logic       o_dom [2];
  logic [1:0] o_sel [2];
  logic [3:0] o_rdy [2];
  assign o_val[0] = bus0.out_val;    assign o_val[1] = bus1.out_val;
  assign o_msg[0] = bus0.out_msg;    assign o_msg[1] = bus1.out_msg;
  assign o_dom[0] = bus0.out_domain; assign o_dom[1] = bus1.out_domain;
  assign o_sel[0] = bus0.out_sel;    assign o_sel[1] = bus1.out_sel;
  assign o_rdy[0] = bus0.in_rdy;     assign o_rdy[1] = bus1.in_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Model: dut0 is round-robin, dut1 is fixed priority; one output slot each.
  logic       m_val [2];
  logic [7:0] m_msg [2];
  logic       m_dom [2];
  int         m_sel [2];
  int         m_ptr;

  function automatic logic [3:0] elig_f();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
`ifdef DOMAIN_FILTER_EN
      e[i] = tb_val[i] && (tb_dom[i] <= tb_clear);
`else
      e[i] = tb_val[i];
`endif
    end
    return e;
  endfunction

  function automatic int winner(input int d);
    logic [3:0] e;
    int start;
    e = elig_f();
    start = (d == 0) ? m_ptr : 0;
    for (int k = 0; k < 4; k++)
      if (e[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_val[d] = 1'b0; m_msg[d] = 8'h00; m_dom[d] = 1'b0; m_sel[d] = 0;
    end
    m_ptr = 0;
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w;
      logic ld;
      w  = winner(d);
      ld = !m_val[d] || tb_ordy;
      if (!reset) begin
        m_val[d] <= 1'b0; m_msg[d] <= 8'h00; m_dom[d] <= 1'b0; m_sel[d] <= 0;
        if (d == 0) m_ptr <= 0;
      end else if (ld) begin
        m_val[d] <= (w >= 0);
        if (w >= 0) begin
          m_msg[d] <= tb_msg[w*8 +: 8];
          m_dom[d] <= tb_dom[w];
          m_sel[d] <= w;
          if (d == 0) m_ptr <= (w + 1) % 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int w;
        logic [3:0] exp_rdy;
        w = winner(d);
        exp_rdy = (reset && (!m_val[d] || tb_ordy) && w >= 0) ? 4'(1 << w) : 4'h0;
        check("in_rdy", d, 32'(o_rdy[d]), 32'(exp_rdy));
        check("out_val", d, 32'(o_val[d]), 32'(m_val[d]));
        check("out_msg", d, 32'(o_msg[d]), 32'(m_msg[d]));
        check("out_domain", d, 32'(o_dom[d]), 32'(m_dom[d]));
        check("out_sel", d, 32'(o_sel[d]), 32'(m_sel[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; chk_en = 1'b0;
    reset = 1'b0; tb_val = 4'hF; tb_msg = 32'h13121110; tb_dom = 4'b1010; tb_ordy = 1'b1;
`ifdef DOMAIN_FILTER_EN
    tb_clear = 1'b1;
`endif
    // Reset with all inputs requesting
    step(); chk_en = 1'b1;
    step();
    check("rst_out_val", 0, 32'(o_val[0]), 32'h0);
    check("rst_out_msg", 0, 32'(o_msg[0]), 32'h0);
    check("rst_in_rdy", 0, 32'(o_rdy[0]), 32'h0);
    reset = 1'b1; #1;
    check("first_grant", 0, 32'(o_rdy[0]), 32'h1);
    check("first_grant", 1, 32'(o_rdy[1]), 32'h1);

    // Round-robin rotation with everyone valid
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_sel", 0, 32'(o_sel[0]), 32'(k % 4));
      check("rr_msg", 0, 32'(o_msg[0]), 32'(8'h10 + (k % 4)));
      check("rr_rdy_onehot", 0, 32'($onehot(o_rdy[0])), 32'h1);
      check("fp_sel", 1, 32'(o_sel[1]), 32'h0);
    end

    // Backpressure holds the captured word
    tb_val = 4'b0100; tb_msg[23:16] = 8'hA5; tb_dom = {1'b0, VC_DOMAIN_H[0], 2'b00};
    step();
    tb_ordy = 1'b0; tb_val = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        check("bp_msg", d, 32'(o_msg[d]), 32'hA5);
        check("bp_dom", d, 32'(o_dom[d]), 32'h1);
        check("bp_sel", d, 32'(o_sel[d]), 32'h2);
        check("bp_rdy", d, 32'(o_rdy[d]), 32'h0);
      end
    end

    // Drain and load in the same cycle
    tb_val = 4'b0010; tb_msg[15:8] = 8'h77; tb_ordy = 1'b1; #1;
    check("dl_rdy", 0, 32'(o_rdy[0]), 32'h2);
    step();
    check("dl_val", 0, 32'(o_val[0]), 32'h1);
    check("dl_msg", 0, 32'(o_msg[0]), 32'h77);
    tb_val = 4'b0000;
    step();
    check("drain_val", 0, 32'(o_val[0]), 32'h0);

    // Fixed priority starves input 3; round-robin alternates 3,1,3
    tb_val = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      check("fp_sel", 1, 32'(o_sel[1]), 32'h1);
      check("rr_alt_sel", 0, 32'(o_sel[0]), (k == 1) ? 32'h1 : 32'h3);
    end

`ifdef DOMAIN_FILTER_EN
    // Clearance gating
    tb_val = 4'b0011; tb_dom = 4'b0001; tb_clear = 1'b0; #1;
    check("flt_rdy", 0, 32'(o_rdy[0]), 32'h2);
    step();
    check("flt_sel", 0, 32'(o_sel[0]), 32'h1);
    check("flt_sel", 1, 32'(o_sel[1]), 32'h1);
    tb_clear = 1'b1;
    step();
    check("flt_clr_sel", 0, 32'(o_sel[0]), 32'h0);
    check("flt_clr_sel", 1, 32'(o_sel[1]), 32'h0);
`endif

    // Random traffic checked against the model
    for (int k = 0; k < 300; k++) begin
      tb_val  = 4'($urandom);
      tb_msg  = $urandom;
      tb_dom  = 4'($urandom);
      tb_ordy = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 40) != 0);
`ifdef DOMAIN_FILTER_EN
      tb_clear = 1'($urandom);
`endif
      step();
    end
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
